// File: rtl/key_load_ctrl_pkg.sv
// rtl/key_load_ctrl_pkg.sv - shared types, defaults and checksum helper for the key loader
package lock_pkg;

  localparam int KEY_W_DEF = 32;
  localparam int CHK_W_DEF = 8;
  // Widest key the checksum helper accepts; narrower keys are zero-extended,
  // which leaves a byte-XOR unchanged.
  localparam int KEY_MAX_W = 256;

  typedef enum logic [1:0] {
    KL_IDLE      = 2'd0,
    KL_SHIFT_KEY = 2'd1,
    KL_SHIFT_CHK = 2'd2,
    KL_CHECK     = 2'd3
  } key_ld_state_t;

  // XOR of every byte of the key.
  function automatic logic [7:0] byte_xor_chk(input logic [KEY_MAX_W-1:0] key);
    logic [7:0] acc;
    acc = '0;
    for (int b = 0; b < KEY_MAX_W / 8; b++) begin
      acc = acc ^ key[8*b +: 8];
    end
    return acc;
  endfunction

endpackage

// File: rtl/key_load_ctrl_if.sv
// rtl/key_load_ctrl_if.sv - control, serial key stream and applied-key bundle
interface key_load_ctrl_if #(
  parameter int KEY_W = 32
);
  logic             load_start_i;
  logic             abort_i;
  logic             key_bit_i;
  logic             key_bit_valid_i;
  logic             key_bit_ready_o;
  logic             busy_o;
  logic [KEY_W-1:0] key_o;
  logic             key_valid_o;
  logic             load_err_o;

  modport master (
    output load_start_i, abort_i, key_bit_i, key_bit_valid_i,
    input  key_bit_ready_o, busy_o, key_o, key_valid_o, load_err_o
  );

  modport slave (
    input  load_start_i, abort_i, key_bit_i, key_bit_valid_i,
    output key_bit_ready_o, busy_o, key_o, key_valid_o, load_err_o
  );
endinterface

// File: rtl/key_load_ctrl.sv
// rtl/key_load_ctrl.sv - serial key loader with byte-XOR check and atomic commit
module key_load_ctrl
  import lock_pkg::*;
#(
  parameter int KEY_W = KEY_W_DEF,
  parameter int CHK_W = CHK_W_DEF
) (
  input logic            clk_i,
  input logic            rst_i,
  key_load_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(KEY_W) + 1;

  localparam logic [1:0] ST_IDLE      = 2'(KL_IDLE);
  localparam logic [1:0] ST_SHIFT_KEY = 2'(KL_SHIFT_KEY);
  localparam logic [1:0] ST_SHIFT_CHK = 2'(KL_SHIFT_CHK);
  localparam logic [1:0] ST_CHECK     = 2'(KL_CHECK);

  logic [1:0]       state_q;
  logic [KEY_W-1:0] shadow_q;
  logic [CHK_W-1:0] chk_q;
  logic [CNT_W-1:0] cnt_q;
  logic             phase_q;   // CHECK: 0 = evaluate checksum, 1 = commit
  logic             ok_q;      // registered checksum match
  logic [KEY_W-1:0] key_q;
  logic             key_valid_q;
  logic             load_err_q;

  logic             take_bit;

  assign take_bit = bus.key_bit_valid_i & ~bus.abort_i;

  // Load sequencer: shift key and checksum, verify, then commit or reject in one edge
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      shadow_q    <= '0;
      chk_q       <= '0;
      cnt_q       <= '0;
      phase_q     <= 1'b0;
      ok_q        <= 1'b0;
      key_q       <= '0;
      key_valid_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.load_start_i) begin
            state_q    <= ST_SHIFT_KEY;
            cnt_q      <= '0;
            shadow_q   <= '0;
            chk_q      <= '0;
            phase_q    <= 1'b0;
            load_err_q <= 1'b0;
          end
        end
        ST_SHIFT_KEY: begin
          if (bus.abort_i) begin
            state_q  <= ST_IDLE;
            shadow_q <= '0;
          end else if (take_bit) begin
            shadow_q <= {shadow_q[KEY_W-2:0], bus.key_bit_i};
            if (cnt_q == CNT_W'(KEY_W - 1)) begin
              cnt_q   <= '0;
              state_q <= ST_SHIFT_CHK;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        ST_SHIFT_CHK: begin
          if (bus.abort_i) begin
            state_q  <= ST_IDLE;
            shadow_q <= '0;
          end else if (take_bit) begin
            chk_q <= {chk_q[CHK_W-2:0], bus.key_bit_i};
            if (cnt_q == CNT_W'(CHK_W - 1)) begin
              cnt_q   <= '0;
              phase_q <= 1'b0;
              state_q <= ST_CHECK;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        ST_CHECK: begin
          if (bus.abort_i) begin
            state_q  <= ST_IDLE;
            shadow_q <= '0;
          end else if (!phase_q) begin
            phase_q <= 1'b1;
            ok_q    <= (byte_xor_chk(KEY_MAX_W'(shadow_q)) == chk_q);
          end else begin
            state_q <= ST_IDLE;
            phase_q <= 1'b0;
            if (ok_q) begin
              key_q       <= shadow_q;
              key_valid_q <= 1'b1;
              load_err_q  <= 1'b0;
            end else begin
              key_q       <= '0;
              key_valid_q <= 1'b0;
              load_err_q  <= 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.key_bit_ready_o = (state_q == ST_SHIFT_KEY) || (state_q == ST_SHIFT_CHK);
  assign bus.busy_o          = (state_q != ST_IDLE);
  assign bus.key_o           = key_q;
  assign bus.key_valid_o     = key_valid_q;
  assign bus.load_err_o      = load_err_q;

endmodule

// File: tb/tb_key_load_ctrl.sv
// tb/tb_key_load_ctrl.sv - bench for key_load_ctrl against a bit-count level model
module tb_key_load_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  key_load_ctrl_if #(.KEY_W(32)) bus ();

  key_load_ctrl #(.KEY_W(32), .CHK_W(8)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a load is just "40 bits collected, then two cycles later the verdict"
  bit          m_busy;
  int          m_n;
  int          m_wait;
  logic [39:0] m_bits;
  logic [31:0] m_key;
  bit          m_valid;
  bit          m_err;

  // Advance the model on each edge from the inputs the bench is driving
  always @(posedge clk) begin
    logic [7:0]  x;
    logic [31:0] k;
    if (rst) begin
      m_busy = 0; m_n = 0; m_wait = 0; m_bits = '0;
      m_key = '0; m_valid = 0; m_err = 0;
    end else if (!m_busy) begin
      if (bus.load_start_i) begin
        m_busy = 1; m_n = 0; m_wait = 0; m_bits = '0; m_err = 0;
      end
    end else if (bus.abort_i) begin
      m_busy = 0;
    end else if (m_n < 40) begin
      if (bus.key_bit_valid_i) begin
        m_bits = {m_bits[38:0], bus.key_bit_i};
        m_n++;
      end
    end else if (m_wait == 0) begin
      m_wait = 1;
    end else begin
      k = m_bits[39:8];
      x = 8'h00;
      for (int b = 0; b < 4; b++) x = x ^ k[8*b +: 8];
      if (x == m_bits[7:0]) begin
        m_key = k; m_valid = 1; m_err = 0;
      end else begin
        m_key = '0; m_valid = 0; m_err = 1;
      end
      m_busy = 0;
    end
  end

  // Compare every DUT output with the model away from the active edge
  always @(negedge clk) begin
    if (checking) begin
      check("cyc_key",   bus.key_o, m_key);
      check("cyc_valid", 32'(bus.key_valid_o), 32'(m_valid));
      check("cyc_err",   32'(bus.load_err_o), 32'(m_err));
      check("cyc_busy",  32'(bus.busy_o), 32'(m_busy));
      check("cyc_ready", 32'(bus.key_bit_ready_o), 32'(m_busy && (m_n < 40)));
    end
  end

  time t0;

  // Pulse load_start_i for one cycle, ending on the next negedge
  task automatic do_start(input bit with_abort);
    bus.load_start_i = 1'b1;
    bus.abort_i      = with_abort;
    t0 = $time;
    @(negedge clk);
    bus.load_start_i = 1'b0;
    bus.abort_i      = 1'b0;
  endtask

  // Stream the first nbits of v (MSB first); optional random gaps and start pulse
  task automatic send(input logic [39:0] v, input bit gaps, input int nbits, input int start_at);
    int  sent = 0;
    int  guard = 0;
    bit  acc;
    while (sent < nbits && guard < 1000) begin
      bus.key_bit_valid_i = !(gaps && ($urandom_range(0, 3) == 0));
      bus.key_bit_i       = v[39 - sent];
      bus.load_start_i    = (sent == start_at);
      acc = bus.key_bit_valid_i && bus.key_bit_ready_o;
      @(negedge clk);
      if (acc) sent++;
      guard++;
    end
    bus.key_bit_valid_i = 1'b0;
    bus.load_start_i    = 1'b0;
    if (sent < nbits) check("send_timeout", 32'(sent), 32'(nbits));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy_o) check("idle_timeout", 32'(bus.busy_o), 32'd0);
  endtask

  initial begin
    int n;
    bus.load_start_i    = 1'b0;
    bus.abort_i         = 1'b0;
    bus.key_bit_i       = 1'b0;
    bus.key_bit_valid_i = 1'b0;
    @(posedge clk);
    #1 checking = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_key",   bus.key_o, 32'h0);
    check("rst_valid", 32'(bus.key_valid_o), 32'd0);
    check("rst_err",   32'(bus.load_err_o), 32'd0);
    check("rst_busy",  32'(bus.busy_o), 32'd0);
    check("rst_ready", 32'(bus.key_bit_ready_o), 32'd0);

    // Good load with continuous valid; commit seen 42 cycles after the start edge
    do_start(1'b0);
    send(40'hB6A1E72D_DD, 1'b0, 40, -1);
    n = 0;
    while (!bus.key_valid_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("good_latency", 32'($time - t0), 32'd430);
    check("good_key",   bus.key_o, 32'hB6A1E72D);
    check("good_valid", 32'(bus.key_valid_o), 32'd1);
    check("good_err",   32'(bus.load_err_o), 32'd0);
    wait_idle();

    // Bad checksum, then a good reload clears the error
    do_start(1'b0);
    send(40'hB6A1E72D_DC, 1'b0, 40, -1);
    wait_idle();
    check("bad_key",   bus.key_o, 32'h0);
    check("bad_valid", 32'(bus.key_valid_o), 32'd0);
    check("bad_err",   32'(bus.load_err_o), 32'd1);
    do_start(1'b0);
    send(40'hB6A1E72D_DD, 1'b0, 40, -1);
    wait_idle();
    check("reload_key", bus.key_o, 32'hB6A1E72D);
    check("reload_err", 32'(bus.load_err_o), 32'd0);

    // Reload with valid gaps; the old key must stay applied until commit
    do_start(1'b0);
    send(40'hB6A1E73D_CD, 1'b1, 40, -1);
    check("hold_key_before_commit", bus.key_o, 32'hB6A1E72D);
    wait_idle();
    check("hold_new_key", bus.key_o, 32'hB6A1E73D);

    // Abort after 20 bits, with a valid bit offered in the abort cycle
    do_start(1'b0);
    send(40'hB6A1E72D_DD, 1'b0, 20, -1);
    bus.abort_i = 1'b1;
    bus.key_bit_valid_i = 1'b1;
    bus.key_bit_i = 1'b1;
    @(negedge clk);
    bus.abort_i = 1'b0;
    check("abort_busy",  32'(bus.busy_o), 32'd0);
    check("abort_ready", 32'(bus.key_bit_ready_o), 32'd0);
    check("abort_key",   bus.key_o, 32'hB6A1E73D);
    check("abort_valid", 32'(bus.key_valid_o), 32'd1);
    repeat (3) begin
      @(negedge clk);
      check("abort_no_accept", 32'(bus.key_bit_ready_o), 32'd0);
    end
    bus.key_bit_valid_i = 1'b0;

    // Reset while shifting the checksum, then a clean load
    do_start(1'b0);
    send(40'hB6A1E72D_DD, 1'b0, 36, -1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_key",   bus.key_o, 32'h0);
    check("midrst_valid", 32'(bus.key_valid_o), 32'd0);
    check("midrst_err",   32'(bus.load_err_o), 32'd0);
    check("midrst_busy",  32'(bus.busy_o), 32'd0);
    check("midrst_ready", 32'(bus.key_bit_ready_o), 32'd0);
    do_start(1'b0);
    send(40'hB6A1E7FD_0D, 1'b0, 40, -1);
    wait_idle();
    check("after_rst_key", bus.key_o, 32'hB6A1E7FD);
    check("after_rst_valid", 32'(bus.key_valid_o), 32'd1);

    // Valid bits in IDLE are dropped; start+abort together starts; start while busy ignored
    for (int i = 0; i < 4; i++) begin
      bus.key_bit_valid_i = 1'b1;
      bus.key_bit_i = i[0];
      @(negedge clk);
      check("idle_busy", 32'(bus.busy_o), 32'd0);
    end
    bus.key_bit_valid_i = 1'b0;
    do_start(1'b1);
    check("start_wins", 32'(bus.busy_o), 32'd1);
    send(40'hB6A1E72D_DD, 1'b0, 40, 10);
    wait_idle();
    check("ignored_key",   bus.key_o, 32'hB6A1E72D);
    check("ignored_valid", 32'(bus.key_valid_o), 32'd1);
    check("ignored_err",   32'(bus.load_err_o), 32'd0);

    repeat (2) @(negedge clk);
    checking = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
